seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 100000, clock cycles per digit slot (legal: DIV >= 2, DIV > BLANK).
REQ-002 SHALL have parameter BLANK, default 16, cycles at the start of each slot with all anodes off (legal: BLANK >= 1).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  request to stage d0..d3 and den as the next frame.
REQ-006 SHALL have ports d0, d1, d2, d3  input  4 each  hex digit values for digits 0..3.
REQ-007 SHALL have port den  input  4  digit enable mask; bit k enables digit k.
REQ-008 SHALL have port an  output  4  active-low anode drives, bit k = digit k.
REQ-009 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL have port sel  output  2  index of the current digit slot.
REQ-011 SHALL have port load_ack  output  1  one-cycle pulse: staged frame became active.

Function
REQ-012 SHALL hold a slot counter cnt counting 0..DIV-1 and wrapping to 0; sel increments on wrap, 3 -> 0.
REQ-013 SHALL run a two-state FSM per slot: BLANK while cnt < BLANK, DRIVE while BLANK <= cnt <= DIV-1; BLANK re-entered on every cnt wrap.
REQ-014 In BLANK, an SHALL be 4'b1111 and seg 7'b1111111.
REQ-015 In DRIVE, an SHALL be all ones except bit sel low when active_den[sel]=1; seg SHALL be hex decode of active digit[sel], or 7'b1111111 if active_den[sel]=0.
REQ-016 an and seg SHALL be registered: one cycle latency from the cnt/sel/state values that select them.
REQ-017 Hex decode (active-low): 0=1000000,1=1111001,2=0100100,3=0110000,4=0011001,5=0010010,6=0000010,7=1111000,8=0000000,9=0010000,A=0001000,b=0000011,C=1000110,d=0100001,E=0000110,F=0001110.
REQ-018 load=1 SHALL capture d0..d3, den into a pending register and set pending flag; a later load before transfer overwrites pending.
REQ-019 Frame boundary = cycle with cnt=DIV-1 and sel=3; at boundary with pending flag set, pending SHALL copy to active and flag clear.
REQ-020 load asserted in the boundary cycle SHALL forward its inputs directly to active (takes priority over older pending) and leave flag clear.
REQ-021 load_ack SHALL pulse high for exactly one cycle, the cycle after any transfer to active; never otherwise.
REQ-022 Active frame SHALL never change except at a frame boundary (no mid-frame tearing).

Reset
REQ-023 On rst=1 at a clock edge: cnt=0, sel=0, FSM=BLANK, an=4'b1111, seg=7'b1111111, load_ack=0, active digits=0, active_den=4'b0000, pending flag=0.
REQ-024 rst SHALL override load in the same cycle; reset mid-frame discards pending and restarts at slot 0 BLANK.

Structure
REQ-025 Hex-to-segment table and blank constant (7'b1111111) SHALL live in shared package seg_pkg.
REQ-026 Decode SHALL be sub-module hex7seg (4-bit in, 7-bit active-low out, pure combinational); cnt width SHALL be $clog2(DIV).

Verification (DIV=8, BLANK=2)
REQ-027 Reset then idle 40 cycles -> an=1111, seg=1111111 throughout, sel cycles 0,1,2,3 every 8 cycles, load_ack never high.
REQ-028 load with d=3,2,1,0, den=1111 mid-frame -> load_ack one cycle after next boundary; following slots show an=1110 seg=0110000, an=1101 seg=0100100, an=1011 seg=1111001, an=0111 seg=1000000, each low for 6 cycles after 2 blank cycles.
REQ-029 Two loads (d0=5 then d0=A) in same frame -> single load_ack; digit 0 shows 0001000.
REQ-030 load d0=F exactly at boundary cycle -> next slot 0 shows seg=0001110, load_ack next cycle.
REQ-031 den=0101 -> an digits 1 and 3 stay high, seg blank in their slots.
REQ-032 rst asserted in slot 2 with pending set -> outputs blank next cycle, sel=0, no load_ack, active cleared.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller.
// Holds the active-low hex segment table and the FSM state codes.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [0:0] S_BLANK = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to active-low 7-segment decoder.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_hex);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with blanking and
// frame-synchronous double-buffered digit updates.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [3:0] den,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic [1:0] sel,
    output logic       load_ack
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
    localparam logic [CW-1:0] BLEN = CW'(BLANK);

    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_sel;
    logic [0:0]      r_state;
    logic [3:0][3:0] r_act_dig;
    logic [3:0]      r_act_den;
    logic [3:0][3:0] r_pnd_dig;
    logic [3:0]      r_pnd_den;
    logic            r_pnd;
    logic            r_ack;
    logic [3:0]      r_an;
    logic [6:0]      r_seg;

    logic            w_wrap;
    logic            w_bound;
    logic            w_xfer;
    logic [CW-1:0]   w_cnt_nxt;
    logic [0:0]      w_state_nxt;
    logic [3:0][3:0] w_ld_dig;
    logic [6:0]      w_hex;
    logic            w_on;

    assign w_wrap      = (r_cnt == CMAX);
    assign w_bound     = w_wrap && (r_sel == 2'd3);
    assign w_xfer      = w_bound && (load || r_pnd);
    assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + CW'(1);
    assign w_state_nxt = (w_cnt_nxt < BLEN) ? S_BLANK : S_DRIVE;
    assign w_ld_dig    = {d3, d2, d1, d0};
    assign w_on        = (r_state == S_DRIVE) && r_act_den[r_sel];

    hex7seg u_dec (
        .i_hex (r_act_dig[r_sel]),
        .o_seg (w_hex)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_sel   <= 2'd0;
            r_state <= S_BLANK;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            if (w_wrap) begin
                r_sel <= r_sel + 2'd1;
            end
        end
    end

    // A load in the boundary cycle bypasses the pending buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pnd     <= 1'b0;
            r_pnd_dig <= '0;
            r_pnd_den <= 4'b0000;
            r_act_dig <= '0;
            r_act_den <= 4'b0000;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_xfer;
            if (w_bound) begin
                r_pnd <= 1'b0;
                if (load) begin
                    r_act_dig <= w_ld_dig;
                    r_act_den <= den;
                end else if (r_pnd) begin
                    r_act_dig <= r_pnd_dig;
                    r_act_den <= r_pnd_den;
                end
            end else if (load) begin
                r_pnd     <= 1'b1;
                r_pnd_dig <= w_ld_dig;
                r_pnd_den <= den;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_on ? ~(4'b0001 << r_sel) : 4'b1111;
            r_seg <= w_on ? w_hex : SEG_BLANK;
        end
    end

    assign an       = r_an;
    assign seg      = r_seg;
    assign sel      = r_sel;
    assign load_ack = r_ack;

endmodule
